// File: rtl/controlador_hd_if.sv
// Core-to-HD-controller bus: request strobes, address/data in, read data and stall out.
interface controlador_hd_if #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned CNT_FW = $clog2(FIFO_DEPTH) + 1;

  logic              Sel_HD_w;
  logic              Sel_HD_r;
  logic [ADDR_W-1:0] hd_addr;
  logic [31:0]       hd_wdata;
  logic [31:0]       HD_out;
  logic              hd_busy;
  logic              hd_rvalid;
  logic [CNT_FW-1:0] fifo_count;

  modport master (
    output Sel_HD_w, Sel_HD_r, hd_addr, hd_wdata,
    input  HD_out, hd_busy, hd_rvalid, fifo_count
  );

  modport slave (
    input  Sel_HD_w, Sel_HD_r, hd_addr, hd_wdata,
    output HD_out, hd_busy, hd_rvalid, fifo_count
  );
endinterface

// File: rtl/controlador_hd.sv
// Slow secondary-storage controller: posted-write FIFO drained in the background,
// reads stall the core until the FIFO is empty and the access latency has elapsed.
module controlador_hd #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned LAT        = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic            clk,
  input logic            reset,
  controlador_hd_if.slave bus
);
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_FW    = PTR_W + 1;
  localparam int unsigned MEM_WORDS = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, WR, RD, RDONE} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_entry_t;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_FW-1:0] count_q, count_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [31:0]       hd_out_q, hd_out_d;
  logic              rvalid_q, rvalid_d;

  wr_entry_t         fifo_q [FIFO_DEPTH];
  logic [31:0]       mem_q  [MEM_WORDS];

  logic full_c, empty_c, push_c, pop_c;

  assign full_c  = (count_q == CNT_FW'(FIFO_DEPTH));
  assign empty_c = (count_q == '0);
  assign push_c  = bus.Sel_HD_w & ~full_c;

  // Sequencer: a pending FIFO entry always wins over a read so reads see prior writes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    raddr_d  = raddr_q;
    hd_out_d = hd_out_q;
    pop_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_c) begin
          state_d = WR;
          cnt_d   = CNT_W'(LAT - 1);
        end else if (bus.Sel_HD_r && !bus.Sel_HD_w) begin
          state_d = RD;
          cnt_d   = CNT_W'(LAT - 1);
          raddr_d = bus.hd_addr;
        end
      end
      WR: begin
        if (cnt_q == '0) begin
          pop_c   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RD: begin
        if (cnt_q == '0) begin
          hd_out_d = mem_q[raddr_q];
          state_d  = RDONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RDONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rvalid_d = (state_d == RDONE);
  end

  // FIFO bookkeeping; a simultaneous push and pop leaves the occupancy unchanged.
  always_comb begin
    head_d  = pop_c  ? head_q + PTR_W'(1) : head_q;
    tail_d  = push_c ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q;
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_FW'(1);
      2'b01:   count_d = count_q - CNT_FW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      raddr_q  <= '0;
      hd_out_q <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      raddr_q  <= raddr_d;
      hd_out_q <= hd_out_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Storage and FIFO payload are not reset; pop_c is low while reset holds state in IDLE.
  always_ff @(posedge clk) begin
    if (pop_c) begin
      mem_q[fifo_q[head_q].addr] <= fifo_q[head_q].data;
    end
    if (push_c) begin
      fifo_q[tail_q] <= '{addr: bus.hd_addr, data: bus.hd_wdata};
    end
  end

  assign bus.HD_out     = hd_out_q;
  assign bus.hd_rvalid  = rvalid_q;
  assign bus.fifo_count = count_q;
  assign bus.hd_busy    = (bus.Sel_HD_w & full_c) | (bus.Sel_HD_r & (state_q != RDONE));
endmodule

// File: tb/tb_controlador_hd.sv
// Directed bench for controlador_hd: reads push expected data to a scoreboard,
// a negedge monitor checks HD_out whenever hd_rvalid pulses.
module tb_controlador_hd;
  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned LAT        = 4;
  localparam int unsigned FIFO_DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  controlador_hd_if #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  controlador_hd #(.ADDR_W(ADDR_W), .LAT(LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] exp_q [$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic void fail_now(string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait bound expired", name);
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.hd_rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_rvalid: got HD_out=0x%08h, expected no read completion", bus.HD_out);
      end else begin
        check("read_data", bus.HD_out, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int a, input logic [31:0] d, output int waits);
    bus.Sel_HD_w = 1'b1;
    bus.hd_addr  = ADDR_W'(a);
    bus.hd_wdata = d;
    waits = 0;
    forever begin
      @(negedge clk);
      if (!bus.hd_busy) break;
      waits++;
      if (waits > 100) begin
        fail_now("write_accept");
        break;
      end
    end
    tick();
    bus.Sel_HD_w = 1'b0;
  endtask

  task automatic do_read(input int a, input logic [31:0] exp, output int stall);
    exp_q.push_back(exp);
    bus.Sel_HD_r = 1'b1;
    bus.hd_addr  = ADDR_W'(a);
    stall = 0;
    forever begin
      @(negedge clk);
      if (!bus.hd_busy) break;
      stall++;
      if (stall > 200) begin
        fail_now("read_complete");
        break;
      end
    end
    tick();
    bus.Sel_HD_r = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.fifo_count == '0) break;
      n++;
      if (n > 200) begin
        fail_now("fifo_drain");
        break;
      end
    end
    tick();
    tick();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w, s;
    logic [31:0] rb_exp [4];
    bus.Sel_HD_w = 1'b0;
    bus.Sel_HD_r = 1'b0;
    bus.hd_addr  = '0;
    bus.hd_wdata = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_HD_out",     bus.HD_out, 32'h0);
    check("reset_rvalid",     32'(bus.hd_rvalid), 32'h0);
    check("reset_fifo_count", 32'(bus.fifo_count), 32'h0);
    check("reset_busy",       32'(bus.hd_busy), 32'h0);
    rst_n = 1'b1;
    tick();

    // Preload addr 5, then a read with the FIFO empty: busy LAT+1 cycles.
    do_write(5, 32'hCAFE_0005, w);
    wait_drain();
    do_read(5, 32'hCAFE_0005, s);
    check("read_empty_stall", 32'(s), 32'd5);
    pulse_reset();
    check("HD_out_after_reset", bus.HD_out, 32'h0);
    do_read(5, 32'hCAFE_0005, s);

    // Read-after-write waits for the drain: (LAT+1)+(LAT+1) stall cycles.
    do_write(3, 32'hDEAD_BEEF, w);
    do_read(3, 32'hDEAD_BEEF, s);
    check("raw_stall", 32'(s), 32'd10);

    // Five back-to-back writes into a depth-4 FIFO.
    for (int i = 0; i < 4; i++) do_write(i, 32'h10 + 32'(i), w);
    check("fifo_full_count", 32'(bus.fifo_count), 32'd4);
    do_write(4, 32'h14, w);
    check("fifo_full_stall", 32'(w), 32'd2);
    check("fifo_after_5th", 32'(bus.fifo_count), 32'd4);
    wait_drain();
    for (int i = 0; i < 5; i++) do_read(i, 32'h10 + 32'(i), s);

    // Push and pop on the same edge with two entries queued, then wrap the pointers.
    do_write(32, 32'hA0, w);
    do_write(33, 32'hA1, w);
    repeat (3) tick();
    do_write(34, 32'hA2, w);
    check("push_pop_count", 32'(bus.fifo_count), 32'd2);
    for (int i = 3; i < 10; i++) do_write(32 + (i % 4), 32'hA0 + 32'(i), w);
    wait_drain();
    rb_exp[0] = 32'hA8;
    rb_exp[1] = 32'hA9;
    rb_exp[2] = 32'hA6;
    rb_exp[3] = 32'hA7;
    for (int i = 0; i < 4; i++) do_read(32 + i, rb_exp[i], s);

    // Reset during RD (cnt=1) with two writes queued; they must never reach storage.
    do_write(50, 32'h5050_5050, w);
    do_write(51, 32'h5151_5151, w);
    wait_drain();
    bus.Sel_HD_r = 1'b1;
    bus.hd_addr  = ADDR_W'(5);
    tick();
    bus.Sel_HD_w = 1'b1;
    bus.hd_addr  = ADDR_W'(50);
    bus.hd_wdata = 32'hBAD0_0050;
    tick();
    bus.hd_addr  = ADDR_W'(51);
    bus.hd_wdata = 32'hBAD0_0051;
    tick();
    bus.Sel_HD_w = 1'b0;
    check("rd_abort_fifo_before", 32'(bus.fifo_count), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("rd_abort_fifo",   32'(bus.fifo_count), 32'd0);
    check("rd_abort_HD_out", bus.HD_out, 32'h0);
    check("rd_abort_busy_r", 32'(bus.hd_busy), 32'd1);
    bus.Sel_HD_r = 1'b0;
    #1;
    check("rd_abort_busy_0", 32'(bus.hd_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_read(50, 32'h5050_5050, s);
    do_read(51, 32'h5151_5151, s);

    // Simultaneous write and read: only the write is taken.
    bus.Sel_HD_w = 1'b1;
    bus.Sel_HD_r = 1'b1;
    bus.hd_addr  = ADDR_W'(60);
    bus.hd_wdata = 32'h6060_6060;
    tick();
    bus.Sel_HD_w = 1'b0;
    bus.Sel_HD_r = 1'b0;
    check("wr_rd_collision_count", 32'(bus.fifo_count), 32'd1);
    wait_drain();
    do_read(60, 32'h6060_6060, s);

    repeat (3) tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/controlador_hd.md
Name: controlador_hd

Overview:
- Secondary-storage (HD) controller sitting directly downstream of the processor core.
- Consumes the core's HD write strobe, HD read strobe, address (low bits of the ALU result) and store data (second register read port).
- Produces the 32-bit HD_out word that the core muxes into the register file, plus a stall signal that freezes the PC during slow accesses.
- Models a slow disk:
  - Writes are posted into a small FIFO and drained in the background, LAT cycles each.
  - Reads wait for the FIFO to drain, then take LAT cycles.

Parameters:
- ADDR_W, 10, word-address width of internal storage (2^ADDR_W 32-bit words).
- LAT, 4, cycles per storage access (read or write); legal range 1..15.
- FIFO_DEPTH, 4, posted-write FIFO entries; power of two, ≥ 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Sel_HD_w  in  1  write request from the control unit.
- Sel_HD_r  in  1  read request from the control unit; held high while hd_busy=1.
- hd_addr  in  ADDR_W  word address.
- hd_wdata  in  32  store data.
- HD_out  out  32  last read data, registered, held until the next read completes.
- hd_busy  out  1  stall request to the core; PC and the current instruction are held while 1.
- hd_rvalid  out  1  one-cycle pulse; HD_out is valid for register write-back this cycle.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied FIFO entries.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, FIFO emptied (pending writes discarded), counter=0.
  - HD_out=0, hd_rvalid=0, fifo_count=0.
  - Storage array is not cleared.
- States: IDLE, WR, RD, RDONE. The counter cnt is loaded with LAT-1 on entry to WR or RD.
- Write acceptance:
  - A write is accepted on an edge where Sel_HD_w=1 and the FIFO is not full; {hd_addr, hd_wdata} is pushed.
  - Accepted in any state except RD/RDONE, which cannot occur because the core is stalled there.
  - If Sel_HD_w=1 and the FIFO is full, the write is not accepted and the core stalls.
- Priority: Sel_HD_w=1 with Sel_HD_r=1 is illegal. The write takes priority and the read is ignored that cycle.
- hd_busy (combinational):
  - (Sel_HD_w & full) | (Sel_HD_r & state!=RDONE).
- IDLE transitions:
  - If the FIFO is non-empty, go to WR. This takes precedence over a pending read, so read-after-write ordering is guaranteed.
  - Else if Sel_HD_r=1, latch hd_addr and go to RD.
  - Else stay in IDLE.
- WR:
  - Decrement cnt each cycle.
  - On the edge where cnt==0: mem[head.addr] <= head.data, pop the FIFO, return to IDLE.
  - WR therefore lasts exactly LAT cycles per entry, with one IDLE cycle between consecutive drains.
  - A push and a pop on the same edge leave fifo_count unchanged.
- RD:
  - Decrement cnt each cycle.
  - On the edge where cnt==0: HD_out <= mem[latched addr], go to RDONE.
- RDONE (exactly one cycle):
  - hd_rvalid=1, hd_busy=0; the core writes HD_out back and advances.
  - Next state is IDLE. A Sel_HD_r still high in the following IDLE cycle is treated as a new read.
- Read latency with the FIFO empty:
  - Request in IDLE at cycle t; RD covers t+1..t+LAT; RDONE at t+LAT+1.
  - hd_busy=1 for cycles t..t+LAT (LAT+1 cycles).
- Read with a non-empty FIFO: the stall extends by (LAT+1) per pending entry before the RD phase starts.
- Pointers: head and tail wrap modulo FIFO_DEPTH. full = (count==FIFO_DEPTH), empty = (count==0).
- Reset mid-operation:
  - Any state is aborted immediately.
  - An in-flight WR entry is not committed; an in-flight read leaves HD_out=0.
- hd_addr and hd_wdata are sampled only on accepting edges; their values at other times are don't-care.

Test Plan:
- Reset, then a read of addr 5 with the FIFO empty, LAT=4 → hd_busy high 5 cycles; hd_rvalid pulses on the 6th cycle with HD_out equal to the preloaded mem[5]; after a mid-test reset, HD_out=0.
- Write 0xDEADBEEF to addr 3, then a read of addr 3 issued the next cycle → the read waits for the drain; HD_out=0xDEADBEEF; total stall = (LAT+1)+(LAT+1)=10 cycles.
- Five back-to-back writes (addr 0..4, data 0x10..0x14), DEPTH=4 → fifo_count reaches 4; the 5th write raises hd_busy until a pop; all five words are later read back correctly.
- Simultaneous push and pop with count=2 during WR completion → fifo_count stays 2; FIFO order is preserved across pointer wrap (10 writes total).
- Assert reset during RD (cnt=1) with 2 FIFO entries → state IDLE, fifo_count=0, hd_busy follows inputs only, the pending writes never appear in storage.
- Sel_HD_w=1 with Sel_HD_r=1 in the same cycle → only the write is accepted (fifo_count +1); no read phase starts that cycle.
